// File: rtl/vec_out_pkg.sv
// Shared constants, state encoding and address-window helper for the
// output-vector serializer.
package vec_out_pkg;

  localparam int VEC_W         = 128;
  localparam int BYTE_W        = 8;
  localparam int BYTES_PER_VEC = 16;

  // Index of the final byte of a vector.
  localparam logic [3:0] LAST_IDX = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Unsigned window test done at 33 bits so base+size never wraps past 2^32.
  function automatic logic in_window(input logic [31:0] a,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    logic [32:0] x;
    logic [32:0] lo;
    logic [32:0] hi;
    x  = {1'b0, a};
    lo = {1'b0, base};
    hi = lo + {1'b0, size};
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vec_fifo.sv
// Vector FIFO: synchronous write, combinational read of the head entry
// (consumed by the caller on pop), full/empty flags, async active-high reset.
// The caller guarantees push is never issued while full without a pop.
module vec_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointer/count values; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});

endmodule

// File: rtl/vec_out_serializer.sv
// Output-vector serializer: captures 128-bit stores that hit the output
// window into a FIFO and streams each vector out LSB byte first over a
// valid/ready byte interface.
// Optional build macro VEC_OUT_CNT_EN adds the 16-bit vec_count output.
module vec_out_serializer
  import vec_out_pkg::*;
#(
  parameter logic [31:0] OUT_BASE = 32'h0000_F000,
  parameter logic [31:0] OUT_SIZE = 32'h0000_0100,
  parameter int          DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wmem,
  input  logic [31:0]  addr,
  input  logic [127:0] wdata,
  output logic [7:0]   byte_out,
  output logic         byte_valid,
  input  logic         byte_ready,
  output logic         full,
`ifdef VEC_OUT_CNT_EN
  output logic [15:0]  vec_count,
`endif
  output logic         busy,
  output logic         ovf
);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   shift_q, shift_d;
  logic [3:0]         idx_q, idx_d;
  logic               ovf_q, ovf_d;

  logic               push_req_s;
  logic               push_s;
  logic               pop_s;
  logic               hs_s;
  logic               last_hs_s;
  logic               full_s;
  logic               empty_s;
  logic [VEC_W-1:0]   fifo_rdata_s;

  assign push_req_s = wmem && in_window(addr, OUT_BASE, OUT_SIZE);
  assign hs_s       = (state_q == SEND) && byte_ready;
  assign last_hs_s  = hs_s && (idx_q == LAST_IDX);

  vec_fifo #(
    .DEPTH (DEPTH),
    .W     (VEC_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (wdata),
    .rdata_o (fifo_rdata_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Serializer FSM next state, FIFO pop/push decisions and overflow capture.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    pop_s   = 1'b0;
    push_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_rdata_s;
          idx_d   = 4'd0;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (hs_s) begin
          if (idx_q == LAST_IDX) begin
            // Chain straight into the next vector to avoid a bubble.
            if (!empty_s) begin
              pop_s   = 1'b1;
              shift_d = fifo_rdata_s;
              idx_d   = 4'd0;
              state_d = SEND;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shift_d = {{BYTE_W{1'b0}}, shift_q[VEC_W-1:BYTE_W]};
            idx_d   = idx_q + 4'd1;
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A store while full fits only if a slot frees up this same cycle.
    if (push_req_s && (!full_s || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (push_req_s && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Serializer state registers; reset discards any vector in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef VEC_OUT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Completed-vector count, wrapping at 16 bits.
  always_comb begin
    if (last_hs_s) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Completed-vector counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign vec_count = cnt_q;
`endif

  assign byte_valid = (state_q == SEND);
  assign byte_out   = shift_q[BYTE_W-1:0];
  assign full       = full_s;
  assign busy       = !empty_s || (state_q == SEND);
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_vec_out_serializer.sv
// Self-checking bench for vec_out_serializer: directed scenarios plus a
// randomized run against a queue-based behavioural model.
module tb_vec_out_serializer;

  localparam logic [31:0] OUT_BASE = 32'h0000_F000;
  localparam logic [31:0] OUT_SIZE = 32'h0000_0100;
  localparam int          DEPTH    = 4;
  localparam logic [127:0] PAT = 128'h0F0E0D0C0B0A09080706050403020100;

  logic         clk = 1'b0;
  logic         rst;
  logic         wmem;
  logic [31:0]  addr;
  logic [127:0] wdata;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         byte_ready;
  logic         full;
  logic         busy;
  logic         ovf;
`ifdef VEC_OUT_CNT_EN
  logic [15:0]  vec_count;
`endif

  int n_vec = 0;
  int n_bad = 0;

  vec_out_serializer #(
    .OUT_BASE (OUT_BASE),
    .OUT_SIZE (OUT_SIZE),
    .DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wmem       (wmem),
    .addr       (addr),
    .wdata      (wdata),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .full       (full),
`ifdef VEC_OUT_CNT_EN
    .vec_count  (vec_count),
`endif
    .busy       (busy),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [127:0] mq[$];
  bit           m_send;
  logic [127:0] m_vec;
  int           m_pos;
  bit           m_ovf;
  int           m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_send = 0; m_vec = '0; m_pos = 0; m_ovf = 0; m_done = 0;
    end else begin
      bit hs, fin, popm, fullb, inwin;
      longint unsigned a, lo, hi;
      a = addr; lo = OUT_BASE; hi = lo + OUT_SIZE;
      inwin = wmem && (a >= lo) && (a < hi);
      hs    = m_send && byte_ready;
      fin   = hs && (m_pos == 15);
      fullb = (mq.size() == DEPTH);
      popm  = (mq.size() > 0) && (!m_send || fin);
      if (fin) m_done++;
      if (hs && !fin) m_pos++;
      if (popm) begin
        m_vec = mq.pop_front(); m_pos = 0; m_send = 1;
      end else if (fin) begin
        m_send = 0;
      end
      if (inwin) begin
        if (!fullb || popm) mq.push_back(wdata);
        else m_ovf = 1;
      end
    end
  end

  task automatic set_store(input logic [31:0] a, input logic [127:0] d);
    wmem = 1'b1; addr = a; wdata = d;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #3;
    n_vec++; if ({byte_valid, byte_out, full, busy, ovf} !== 12'h000) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 000", {byte_valid, byte_out, full, busy, ovf});
    end
    repeat (2) @(negedge clk);
    n_vec++; if ({byte_valid, full, busy, ovf} !== 4'h0) begin
      n_bad++; $display("FAIL reset_held: got %h want 0", {byte_valid, full, busy, ovf});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_store();
    @(negedge clk);
    byte_ready = 1'b1;
    set_store(OUT_BASE, PAT);
    @(negedge clk);
    wmem = 1'b0;
    n_vec++; if (byte_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL single_latency: valid=%b busy=%b want valid=0 busy=1", byte_valid, busy);
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (byte_valid !== 1'b1 || byte_out !== 8'(i)) begin
        n_bad++; $display("FAIL single_byte%0d: valid=%b byte=%h want 1/%h", i, byte_valid, byte_out, 8'(i));
      end
      @(negedge clk);
    end
    n_vec++; if (byte_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL single_done: valid=%b busy=%b want 0/0", byte_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    byte_ready = 1'b1;
    set_store(OUT_BASE + 32'd32, PAT);
    @(negedge clk);
    wmem = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (byte_valid !== 1'b1 || byte_out !== 8'(i)) begin
        n_bad++; $display("FAIL bp_byte%0d: valid=%b byte=%h want 1/%h", i, byte_valid, byte_out, 8'(i));
      end
      if (i == 3) begin
        byte_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          n_vec++; if (byte_valid !== 1'b1 || byte_out !== 8'h03) begin
            n_bad++; $display("FAIL bp_hold%0d: valid=%b byte=%h want 1/03", s, byte_valid, byte_out);
          end
        end
        byte_ready = 1'b1;
      end
      @(negedge clk);
    end
    n_vec++; if (busy !== 1'b0) begin
      n_bad++; $display("FAIL bp_done: busy=%b want 0", busy);
    end
  endtask

  task automatic test_window_bounds();
    byte_ready = 1'b1;
    set_store(OUT_BASE - 32'd16, rnd128());
    @(negedge clk);
    set_store(OUT_BASE + OUT_SIZE, rnd128());
    @(negedge clk);
    wmem = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_vec++; if (busy !== 1'b0 || byte_valid !== 1'b0) begin
        n_bad++; $display("FAIL window_c%0d: busy=%b valid=%b want 0/0", c, busy, byte_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overflow();
    logic [127:0] v[6];
    int got;
    byte_ready = 1'b0;
    for (int k = 0; k < 6; k++) v[k] = rnd128();
    for (int k = 0; k < 6; k++) begin
      set_store(OUT_BASE + 32'(k * 16), v[k]);
      @(negedge clk);
      // k+1 stores sampled; one went straight to the shift register.
      n_vec++; if (full !== ((k + 1) >= DEPTH + 1)) begin
        n_bad++; $display("FAIL ovf_full_after%0d: full=%b want %b", k + 1, full, ((k + 1) >= DEPTH + 1));
      end
    end
    wmem = 1'b0;
    n_vec++; if (ovf !== 1'b1 || full !== 1'b1) begin
      n_bad++; $display("FAIL ovf_set: ovf=%b full=%b want 1/1", ovf, full);
    end
    byte_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      if (byte_valid) begin
        if (got >= 80) begin
          n_vec++; n_bad++; $display("FAIL ovf_extra_byte: got byte %0d want at most 80", got);
        end else begin
          n_vec++; if (byte_out !== v[got / 16][(got % 16) * 8 +: 8]) begin
            n_bad++; $display("FAIL ovf_byte%0d: got %h want %h", got, byte_out, v[got / 16][(got % 16) * 8 +: 8]);
          end
        end
        got++;
      end
      @(negedge clk);
    end
    n_vec++; if (got !== 80 || ovf !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL ovf_drain: bytes=%0d ovf=%b busy=%b want 80/1/0", got, ovf, busy);
    end
    rst = 1'b1;
    #1;
    n_vec++; if (ovf !== 1'b0) begin
      n_bad++; $display("FAIL ovf_clear: ovf=%b want 0", ovf);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b;
    logic [255:0] both;
    a = rnd128(); b = rnd128(); both = {b, a};
    byte_ready = 1'b1;
    set_store(OUT_BASE + 32'h10, a);
    @(negedge clk);
    set_store(OUT_BASE + 32'h20, b);
    @(negedge clk);
    wmem = 1'b0;
    for (int i = 0; i < 32; i++) begin
      n_vec++; if (byte_valid !== 1'b1 || byte_out !== both[i * 8 +: 8]) begin
        n_bad++; $display("FAIL b2b_byte%0d: valid=%b byte=%h want 1/%h", i, byte_valid, byte_out, both[i * 8 +: 8]);
      end
      @(negedge clk);
    end
    n_vec++; if (byte_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_done: valid=%b busy=%b want 0/0", byte_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    byte_ready = 1'b1;
    set_store(OUT_BASE, PAT);
    @(negedge clk);
    set_store(OUT_BASE + 32'h40, rnd128());
    @(negedge clk);
    wmem = 1'b0;
    c = 0;
    while (c < 40 && !(byte_valid === 1'b1 && byte_out === 8'h07)) begin
      @(negedge clk);
      c++;
    end
    n_vec++; if (c >= 40) begin
      n_bad++; $display("FAIL rstmid_wait: byte 07 not seen within %0d cycles", c);
    end
    rst = 1'b1;
    #1;
    n_vec++; if ({byte_valid, byte_out, full, busy} !== 11'h000) begin
      n_bad++; $display("FAIL rstmid_now: got %h want 000", {byte_valid, byte_out, full, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++; if (byte_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL rstmid_after%0d: valid=%b busy=%b want 0/0", k, byte_valid, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_vec++; if (byte_valid !== m_send || full !== (mq.size() == DEPTH) ||
                   busy !== (mq.size() > 0 || m_send) || ovf !== m_ovf) begin
        n_bad++; $display("FAIL rand_flags c%0d: v/f/b/o=%b%b%b%b want %b%b%b%b", c, byte_valid, full, busy, ovf,
                          m_send, (mq.size() == DEPTH), (mq.size() > 0 || m_send), m_ovf);
      end
      if (m_send) begin
        n_vec++; if (byte_out !== m_vec[m_pos * 8 +: 8]) begin
          n_bad++; $display("FAIL rand_byte c%0d: got %h want %h", c, byte_out, m_vec[m_pos * 8 +: 8]);
        end
      end
`ifdef VEC_OUT_CNT_EN
      n_vec++; if (vec_count !== 16'(m_done)) begin
        n_bad++; $display("FAIL rand_count c%0d: got %0d want %0d", c, vec_count, 16'(m_done));
      end
`endif
      case ($urandom_range(0, 6))
        0:       a = OUT_BASE + ($urandom % OUT_SIZE);
        1:       a = OUT_BASE;
        2:       a = OUT_BASE + OUT_SIZE - 32'd1;
        3:       a = OUT_BASE + OUT_SIZE;
        4:       a = OUT_BASE - 32'd1;
        5:       a = OUT_BASE + ($urandom % OUT_SIZE);
        default: a = $urandom;
      endcase
      wmem       = ($urandom_range(0, 9) < 2);
      addr       = a;
      wdata      = rnd128();
      byte_ready = ($urandom_range(0, 3) != 0);
    end
    wmem = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wmem = 1'b0; addr = '0; wdata = '0; byte_ready = 1'b0;
    test_reset();
    test_single_store();
    test_backpressure();
    test_window_bounds();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
